// File: rtl/pdm_pkg.sv
// Shared constants and mode encoding for the process delay model.
package pdm_pkg;

  localparam int MODE_TRANSPORT = 0;
  localparam int MODE_INERTIAL  = 1;
  localparam int DELAY_MAX      = 1024;

  typedef enum logic {
    PDM_TRANSPORT = 1'b0,
    PDM_INERTIAL  = 1'b1
  } pdm_mode_e;

  function automatic bit pdm_mode_legal(input int mode);
    return (mode == MODE_TRANSPORT) || (mode == MODE_INERTIAL);
  endfunction

endpackage

// File: rtl/pdm_shift_line.sv
// Sample history: taps[0] is the newest sample and taps[DEPTH-1] the oldest.
module pdm_shift_line #(
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [DEPTH-1:0] taps
);

  logic [DEPTH-1:0] taps_q;
  logic [DEPTH-1:0] taps_d;

  // The shift form is also valid when DEPTH is 1.
  always_comb begin
    taps_d = (taps_q << 1) | DEPTH'(din);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taps_q <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign taps = taps_q;

endmodule

// File: rtl/process_delay_model.sv
// Transport or inertial delay of a single wire by DELAY clock cycles.
module process_delay_model
  import pdm_pkg::*;
#(
  parameter int DELAY = 10,
  parameter int MODE  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic wire_in,
  output logic wire_out
);

  if (DELAY < 1 || DELAY > DELAY_MAX) begin : g_bad_delay
    $error("process_delay_model: DELAY=%0d outside 1..%0d", DELAY, DELAY_MAX);
  end
  if (!pdm_mode_legal(MODE)) begin : g_bad_mode
    $error("process_delay_model: MODE=%0d is neither transport nor inertial", MODE);
  end

  localparam pdm_mode_e MODE_SEL = (MODE == MODE_INERTIAL) ? PDM_INERTIAL : PDM_TRANSPORT;

  logic [DELAY-1:0] taps;
  logic             all_ones;
  logic             all_zeros;
  logic             wire_out_q;
  logic             wire_out_d;

  pdm_shift_line #(
    .DEPTH(DELAY)
  ) u_line (
    .clk (clk),
    .rst (rst),
    .din (wire_in),
    .taps(taps)
  );

  assign all_ones  = &taps;
  assign all_zeros = ~|taps;

  // Inertial mode only moves when the whole window agrees; otherwise it holds.
  always_comb begin
    wire_out_d = wire_out_q;
    case (MODE_SEL)
      PDM_TRANSPORT: wire_out_d = taps[DELAY-1];
      PDM_INERTIAL: begin
        if (all_ones) begin
          wire_out_d = 1'b1;
        end else if (all_zeros) begin
          wire_out_d = 1'b0;
        end
      end
      default: wire_out_d = wire_out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wire_out_q <= 1'b0;
    end else begin
      wire_out_q <= wire_out_d;
    end
  end

  assign wire_out = wire_out_q;

endmodule

// File: tb/tb_process_delay_model.sv
// Bench for process_delay_model: five configurations side by side, a queue-based
// reference model feeding a scoreboard, plus directed latency/width checks.
module tb_process_delay_model;

  localparam int N = 5;
  localparam int DLY [N] = '{10, 10, 1, 1, 1024};
  localparam int MD  [N] = '{1, 0, 0, 1, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst  [N];
  logic win  [N];
  logic wout [N];

  process_delay_model #(.DELAY(10),   .MODE(1)) u_d10_inertial  (.clk(clk), .rst(rst[0]), .wire_in(win[0]), .wire_out(wout[0]));
  process_delay_model #(.DELAY(10),   .MODE(0)) u_d10_transport (.clk(clk), .rst(rst[1]), .wire_in(win[1]), .wire_out(wout[1]));
  process_delay_model #(.DELAY(1),    .MODE(0)) u_d1_transport  (.clk(clk), .rst(rst[2]), .wire_in(win[2]), .wire_out(wout[2]));
  process_delay_model #(.DELAY(1),    .MODE(1)) u_d1_inertial   (.clk(clk), .rst(rst[3]), .wire_in(win[3]), .wire_out(wout[3]));
  process_delay_model #(.DELAY(1024), .MODE(1)) u_d1024_inertial(.clk(clk), .rst(rst[4]), .wire_in(win[4]), .wire_out(wout[4]));

  logic exp_q    [N][$];
  bit   hist     [N][$];
  logic prev_exp [N];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: window of the last DELAY samples, oldest at the front.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      logic e;
      bit   settled;
      if (rst[i]) begin
        hist[i].delete();
        for (int j = 0; j < DLY[i]; j++) hist[i].push_back(1'b0);
        e = 1'b0;
      end else begin
        settled = 1'b1;
        foreach (hist[i][j]) if (hist[i][j] != hist[i][0]) settled = 1'b0;
        if (MD[i] == 0) e = hist[i][0];
        else            e = settled ? logic'(hist[i][0]) : prev_exp[i];
        hist[i].push_back(win[i]);
        void'(hist[i].pop_front());
      end
      prev_exp[i] = e;
      exp_q[i].push_back(e);
    end
  end

  // Monitor: every output value is compared against the model's prediction.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (exp_q[i].size() != 0) begin
        logic e;
        e = exp_q[i].pop_front();
        n_cmp++;
        if (wout[i] !== e) begin
          n_err++;
          $display("FAIL scoreboard inst%0d @%0t: wire_out=%b expected=%b", i, $time, wout[i], e);
        end
      end
    end
  end

  task automatic check(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  logic val [N];
  int   run [N];

  initial begin
    int rise0, fall0, hi0, first1, hi1, hi4a, hi4b, first4;
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1;
      win[i] = 1'b0;
      val[i] = 1'b0;
      run[i] = 0;
    end

    // Reset for three edges, then confirm every output is low.
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) check($sformatf("reset_out%0d", i), int'(wout[i]), 0);

    // Directed window: t is the edge index counted from the first post-reset sample.
    rise0 = -1; fall0 = -1; hi0 = 0; first1 = -1; hi1 = 0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) rst[i] = 1'b0;
      rst[1] = (t == 48);
      win[0] = ((t >= 3 && t < 6) || (t >= 26 && t < 46));
      win[1] = ((t >= 3 && t < 6) || (t >= 40 && t < 43));
      win[2] = logic'(t % 2);
      win[3] = logic'(t % 2);
      win[4] = 1'b0;
      @(posedge clk); #1;
      if (wout[0]) hi0++;
      if (wout[0] && rise0 < 0) rise0 = t;
      if (!wout[0] && rise0 >= 0 && fall0 < 0) fall0 = t;
      if (wout[1]) hi1++;
      if (wout[1] && first1 < 0) first1 = t;
      check("d1_transport_toggle", int'(wout[2]), (t >= 1) ? (t - 1) % 2 : 0);
      check("d1_inertial_toggle",  int'(wout[3]), (t >= 1) ? (t - 1) % 2 : 0);
    end
    check("inertial_rise_edge", rise0, 36);
    check("inertial_fall_edge", fall0, 56);
    check("inertial_high_cycles", hi0, 20);
    check("transport_first_high", first1, 13);
    check("transport_high_cycles_after_reset", hi1, 3);

    // Random run-length stimulus with occasional resets.
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (run[i] == 0) begin
          val[i] = ~val[i];
          run[i] = $urandom_range(1, 14);
        end
        run[i]--;
        win[i] = val[i];
        rst[i] = ($urandom_range(0, 60) == 0);
      end
    end

    // DELAY=1024 inertial: 1023-cycle pulse must vanish, 1024-cycle pulse must pass.
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      rst[i] = (i == 4);
      win[i] = 1'b0;
    end
    hi4a = 0; hi4b = 0; first4 = -1;
    for (int t = 0; t < 4400; t++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) rst[i] = 1'b0;
      win[4] = ((t >= 10 && t < 10 + 1023) || (t >= 2200 && t < 2200 + 1024));
      @(posedge clk); #1;
      if (wout[4]) begin
        if (t < 2200) hi4a++;
        else begin
          hi4b++;
          if (first4 < 0) first4 = t;
        end
      end
    end
    check("d1024_short_pulse_suppressed", hi4a, 0);
    check("d1024_long_pulse_first_high", first4, 2200 + 1024);
    check("d1024_long_pulse_width", hi4b, 1024);

    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/process_delay_model.md
PROCESS_DELAY_MODEL -- requirements
Module: process_delay_model

Interface
REQ-001 Parameter DELAY, default 10, delay in clock cycles; legal range 1..1024.
REQ-002 Parameter MODE, default 1 (inertial); 0 = transport, 1 = inertial.
REQ-003 Any DELAY or MODE outside its legal range SHALL cause an elaboration-time error.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port wire_in, input, 1 bit: signal being delayed, sampled on each clk rising edge.
REQ-007 Port wire_out, output, 1 bit: delayed signal, driven directly from a register.

Function
REQ-008 The block SHALL keep a sample history of the last DELAY values of wire_in, s[m-DELAY..m-1], where s[j] is wire_in sampled at edge j.
REQ-009 Transport mode (MODE=0): at each non-reset edge m, wire_out SHALL take s[m-DELAY]; every input pulse, including 1-cycle pulses, is reproduced with its width preserved.
REQ-010 Inertial mode (MODE=1): at edge m, wire_out SHALL take value v only if all of s[m-DELAY..m-1] equal v; otherwise it SHALL hold its value.
REQ-011 Inertial mode SHALL suppress any input pulse shorter than DELAY cycles, so it never appears on wire_out.
REQ-012 Latency: a level change first sampled at edge k that is held for at least DELAY cycles SHALL appear on wire_out at edge k+DELAY, in both modes.
REQ-013 DELAY=1: both modes SHALL behave as one register stage (wire_out = previous sample).
REQ-014 wire_out SHALL have no combinational path from wire_in.
REQ-015 Sampled input values SHALL be treated as 0/1 only; X/Z handling is not defined.

Reset
REQ-016 While rst=1 at a rising edge, wire_out SHALL be 0 at that edge.
REQ-017 While rst=1 at a rising edge, the whole sample history SHALL be cleared to 0 at that edge.
REQ-018 Reset asserted mid-operation SHALL discard all in-flight transitions.
REQ-019 After rst deasserts, the first sample SHALL be taken at the next edge, and the history SHALL fill from that edge.

Structure
REQ-020 A shared package pdm_pkg SHALL hold MODE_TRANSPORT=0, MODE_INERTIAL=1 and DELAY_MAX=1024.
REQ-021 The sample history SHALL be a sub-module pdm_shift_line (parameter DEPTH, ports clk, rst, din, taps[DEPTH-1:0]).
REQ-022 The top level SHALL contain the mode-select output logic and the all-equal detection (all-ones / all-zeros reduction) over the taps.

Verification
REQ-023 DELAY=10, MODE=1: wire_in=0; 1 for 3 cycles starting edge 3 -> wire_out stays 0 throughout.
REQ-024 DELAY=10, MODE=1: wire_in rises at edge 26 and holds 20 cycles -> wire_out rises at edge 36; input falls at edge 46 -> wire_out falls at edge 56.
REQ-025 DELAY=10, MODE=0: 3-cycle pulse starting edge 3 -> wire_out is 1 for edges 13..15 exactly.
REQ-026 DELAY=10, MODE=0: assert rst for 1 cycle at edge 8, mid-pulse -> wire_out 0 afterwards, no pulse emitted.
REQ-027 DELAY=1: toggle wire_in every cycle -> in both modes wire_out is the same toggle, one cycle late.
REQ-028 DELAY=1024, MODE=1: 1023-cycle high pulse -> suppressed; 1024-cycle high pulse -> wire_out high for exactly 1024 cycles starting 1024 cycles after the rise.
